// File: rtl/frv_arb_pkg.sv
// frv_arb_pkg -- shared types and defaults for the frv_8 Wishbone arbiter.
//   arb_state_e : arbiter FSM state (IDLE, imem granted, dmem granted)
//   TO_DATA_DEF : read data handed back to a requester whose transfer timed out
package frv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam logic [31:0] TO_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/frv_arb_wdog.sv
// frv_arb_wdog -- per-transfer watchdog counter.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : hold the counter at zero (arbiter idle)
//   en_i         : count one granted cycle without acknowledge
//   exp_o        : counter sits on its last allowed cycle (TIMEOUT-1);
//                  constant 0 when TIMEOUT == 0
module frv_arb_wdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic exp_o
);

    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign exp_o = (TIMEOUT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/frv_wb_arb.sv
// frv_wb_arb -- shares one Wishbone-classic port between the frv_8 imem and
// dmem buses. Round-robin on ties, registered grant, per-transfer watchdog.
//   clk_i, rst_i        : clock, async active-high reset
//   i_*                 : imem slave side (read only)
//   d_*                 : dmem slave side (read/write, byte enables)
//   m_*                 : shared master port towards SRAM/peripherals
//   to_o                : one-cycle pulse when the watchdog ends a transfer
//   busy_o              : a grant is held
module frv_wb_arb
    import frv_arb_pkg::*;
#(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = TO_DATA_DEF,
    parameter int          CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_cyc_i,
    input  logic        i_stb_i,
    input  logic [31:0] i_adr_i,
    output logic [31:0] i_dat_o,
    output logic        i_ack_o,
    input  logic        d_cyc_i,
    input  logic        d_stb_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_dat_i,
    output logic [31:0] d_dat_o,
    output logic        d_ack_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        to_o,
    output logic        busy_o
);

    arb_state_e state_q, state_d;
    logic       last_d_q, last_d_d;
    logic       req_i, req_d, sel_cyc, wd_exp, tmo;

    assign req_i  = i_cyc_i & i_stb_i;
    assign req_d  = d_cyc_i & d_stb_i;
    assign busy_o = (state_q != IDLE);

    // cyc of whichever side currently owns the port; dropping it aborts
    assign sel_cyc = (state_q == GNT_I) ? i_cyc_i :
                     (state_q == GNT_D) ? d_cyc_i : 1'b0;

    // A real ack in the last watchdog cycle wins over the timeout
    assign tmo = wd_exp & busy_o & sel_cyc & ~m_ack_i;

    frv_arb_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (~busy_o),
        .en_i  (busy_o & ~m_ack_i),
        .exp_o (wd_exp)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Next state: a grant is only taken from IDLE, so every transfer is
    // followed by at least one idle cycle.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (req_d && (!req_i || !last_d_q)) begin
                    state_d  = GNT_D;
                    last_d_d = 1'b1;
                end else if (req_i) begin
                    state_d  = GNT_I;
                    last_d_d = 1'b0;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ack_i || !sel_cyc || tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Port mux and ack/data routing
    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_be_o  = 4'h0;
        m_adr_o = '0;
        m_dat_o = '0;
        i_ack_o = 1'b0;
        i_dat_o = '0;
        d_ack_o = 1'b0;
        d_dat_o = '0;
        to_o    = tmo;
        case (state_q)
            GNT_I: begin
                m_cyc_o = i_cyc_i;
                m_stb_o = i_stb_i;
                m_be_o  = 4'hF;
                m_adr_o = i_adr_i;
                i_ack_o = m_ack_i | tmo;
                i_dat_o = tmo ? TO_DATA : m_dat_i;
            end
            GNT_D: begin
                m_cyc_o = d_cyc_i;
                m_stb_o = d_stb_i;
                m_we_o  = d_we_i;
                m_be_o  = d_be_i;
                m_adr_o = d_adr_i;
                m_dat_o = d_dat_i;
                d_ack_o = m_ack_i | tmo;
                d_dat_o = tmo ? TO_DATA : m_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_frv_wb_arb.sv
module tb_frv_wb_arb;

    localparam int          TMO = 4;
    localparam logic [31:0] TOD = 32'hDEAD_BEEF;

    typedef struct packed {
        logic rst, ic, is; logic [31:0] ia;
        logic dc, ds, dwe; logic [3:0] dbe; logic [31:0] da, dd, md;
        logic mack;
    } in_t;

    typedef struct packed {
        logic mcyc, mstb, mwe; logic [3:0] mbe; logic [31:0] madr, mdo;
        logic iack; logic [31:0] ido;
        logic dack; logic [31:0] ddo;
        logic to, busy;
    } out_t;

    typedef struct packed { in_t i; out_t o; } vec_t;

    logic        clk, rst_i;
    logic        i_cyc_i, i_stb_i, i_ack_o, d_cyc_i, d_stb_i, d_we_i, d_ack_o;
    logic [31:0] i_adr_i, i_dat_o, d_adr_i, d_dat_i, d_dat_o;
    logic [3:0]  d_be_i, m_be_o;
    logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i, to_o, busy_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    out_t        act;

    int nchk = 0, npass = 0;

    frv_wb_arb #(.TIMEOUT(TMO), .TO_DATA(TOD), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_adr_i(i_adr_i), .i_dat_o(i_dat_o), .i_ack_o(i_ack_o),
        .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_adr_i(d_adr_i),
        .d_dat_i(d_dat_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .to_o(to_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = '{m_cyc_o, m_stb_o, m_we_o, m_be_o, m_adr_o, m_dat_o,
                   i_ack_o, i_dat_o, d_ack_o, d_dat_o, to_o, busy_o};

    task automatic drive(input in_t v);
        rst_i = v.rst; i_cyc_i = v.ic; i_stb_i = v.is; i_adr_i = v.ia;
        d_cyc_i = v.dc; d_stb_i = v.ds; d_we_i = v.dwe; d_be_i = v.dbe;
        d_adr_i = v.da; d_dat_i = v.dd; m_dat_i = v.md; m_ack_i = v.mack;
    endtask

    // Apply one cycle of inputs just after the edge, return at the sampling point
    task automatic step(input in_t v);
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input int idx, input out_t exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
    endtask

    task automatic chk32(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
    endtask

    // Reference model: who owns the port, who won last, how long we have waited
    int m_own, m_lastd, m_wait;

    task automatic model(input in_t v, output out_t e);
        logic cyc, hit;
        e = '0;
        if (v.rst) begin m_own = 0; m_lastd = 0; m_wait = 0; return; end
        if (m_own == 0) begin
            if (v.dc && v.ds && (!(v.ic && v.is) || m_lastd == 0)) begin
                m_own = 2; m_lastd = 1; m_wait = 0;
            end else if (v.ic && v.is) begin
                m_own = 1; m_lastd = 0; m_wait = 0;
            end
            return;
        end
        cyc = (m_own == 1) ? v.ic : v.dc;
        hit = (TMO > 0) && cyc && !v.mack && (m_wait == TMO - 1);
        e.busy = 1'b1;
        e.mcyc = cyc;
        e.to   = hit;
        if (m_own == 1) begin
            e.mstb = v.is; e.madr = v.ia; e.mbe = 4'hF;
            e.iack = v.mack | hit; e.ido = hit ? TOD : v.md;
        end else begin
            e.mstb = v.ds; e.madr = v.da; e.mbe = v.dbe; e.mwe = v.dwe; e.mdo = v.dd;
            e.dack = v.mack | hit; e.ddo = hit ? TOD : v.md;
        end
        if (v.mack || !cyc || hit) m_own = 0;
        else m_wait++;
    endtask

    localparam out_t OZ = '0;
    vec_t tbl[19];

    initial begin
        in_t  v;
        out_t e;
        int   npulse;

        drive('{rst: 1'b1, default: '0});

        // rst ic is ia dc ds dwe dbe da dd md mack ; mcyc mstb mwe mbe madr mdo iack ido dack ddo to busy
        tbl[0]  = '{'{1,0,0,0,1,1,0,4'hF,32'h100,0,32'h12345678,0}, OZ};
        tbl[1]  = '{'{0,0,0,0,1,1,0,4'hF,32'h100,0,32'h12345678,0}, OZ};
        tbl[2]  = '{'{0,0,0,0,1,1,0,4'hF,32'h100,0,32'h12345678,0}, '{1,1,0,4'hF,32'h100,0,0,0,0,32'h12345678,0,1}};
        tbl[3]  = '{'{0,0,0,0,1,1,0,4'hF,32'h100,0,32'h12345678,1}, '{1,1,0,4'hF,32'h100,0,0,0,1,32'h12345678,0,1}};
        tbl[4]  = '{'{0,0,0,0,0,0,0,0,0,0,32'h12345678,0}, OZ};
        tbl[5]  = '{'{0,0,0,0,1,1,1,4'b0011,32'h300,32'hAABBCCDD,0,0}, OZ};
        tbl[6]  = '{'{0,1,1,32'h200,1,1,1,4'b0011,32'h300,32'hAABBCCDD,0,0}, '{1,1,1,4'b0011,32'h300,32'hAABBCCDD,0,0,0,0,0,1}};
        tbl[7]  = '{'{0,1,1,32'h200,1,1,1,4'b0011,32'h300,32'hAABBCCDD,0,1}, '{1,1,1,4'b0011,32'h300,32'hAABBCCDD,0,0,1,0,0,1}};
        tbl[8]  = '{'{0,1,1,32'h200,0,0,0,0,0,0,0,0}, OZ};
        tbl[9]  = '{'{0,1,1,32'h200,0,0,0,0,0,0,32'h0BADF00D,1}, '{1,1,0,4'hF,32'h200,0,1,32'h0BADF00D,0,0,0,1}};
        tbl[10] = '{'{0,0,0,0,1,1,0,4'hF,32'h400,0,0,0}, OZ};
        tbl[11] = '{'{0,0,0,0,1,1,0,4'hF,32'h400,0,0,0}, '{1,1,0,4'hF,32'h400,0,0,0,0,0,0,1}};
        tbl[12] = '{'{0,0,0,0,0,0,0,4'hF,32'h400,0,0,0}, '{0,0,0,4'hF,32'h400,0,0,0,0,0,0,1}};
        tbl[13] = '{'{0,0,0,0,0,0,0,0,0,0,0,0}, OZ};
        tbl[14] = '{'{0,0,0,0,1,1,0,4'hF,32'h500,0,0,0}, OZ};
        tbl[15] = '{'{0,0,0,0,1,1,0,4'hF,32'h500,0,0,0}, '{1,1,0,4'hF,32'h500,0,0,0,0,0,0,1}};
        tbl[16] = '{'{1,0,0,0,1,1,0,4'hF,32'h500,0,32'h77,1}, OZ};
        tbl[17] = '{'{0,1,1,32'h600,1,1,0,4'hF,32'h700,0,0,0}, OZ};
        tbl[18] = '{'{0,1,1,32'h600,1,1,0,4'hF,32'h700,0,0,0}, '{1,1,0,4'hF,32'h700,0,0,0,0,0,0,1}};

        for (int k = 0; k < 19; k++) begin
            step(tbl[k].i);
            chk_out("vec", k, tbl[k].o);
        end

        // Round robin: both request forever, memory acks every cycle
        step('{rst: 1'b1, default: '0});
        v = '{ic: 1'b1, is: 1'b1, ia: 32'hA0, dc: 1'b1, ds: 1'b1, dbe: 4'hF, da: 32'hB0,
              md: 32'h55, mack: 1'b1, default: '0};
        for (int k = 0; k < 8; k++) begin
            step(v);
            chk32("rr_adr", k, m_adr_o, (k % 2 == 0) ? 32'h0 : (k % 4 == 1) ? 32'hB0 : 32'hA0);
            chk32("rr_ack", k, {30'b0, d_ack_o, i_ack_o},
                  (k % 2 == 0) ? 32'h0 : (k % 4 == 1) ? 32'h2 : 32'h1);
        end

        // Watchdog expiry: imem fetch, memory silent
        step('{rst: 1'b1, default: '0});
        v = '{ic: 1'b1, is: 1'b1, ia: 32'hC0, md: 32'h1111, default: '0};
        npulse = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) v.ic = 1'b0;
            step(v);
            npulse += int'(to_o);
            chk32("to_iack", k, {31'b0, i_ack_o}, {31'b0, k == 4});
            if (k == 4) chk32("to_idat", k, i_dat_o, TOD);
            if (k == 5) chk32("to_idle", k, {31'b0, busy_o}, 32'h0);
        end
        chk32("to_pulses", 0, npulse, 1);

        // Real ack on the last watchdog cycle wins
        step('{rst: 1'b1, default: '0});
        v = '{ic: 1'b1, is: 1'b1, ia: 32'hC4, md: 32'h13579BDF, default: '0};
        for (int k = 0; k < 5; k++) begin
            v.mack = (k == 4);
            step(v);
            if (k == 4) begin
                chk32("late_ack", k, {31'b0, i_ack_o}, 32'h1);
                chk32("late_dat", k, i_dat_o, 32'h13579BDF);
                chk32("late_to", k, {31'b0, to_o}, 32'h0);
            end
        end

        // Random traffic against the reference model
        v = '{rst: 1'b1, default: '0};
        step(v);
        model(v, e);
        chk_out("rnd", 0, e);
        for (int k = 1; k < 3000; k++) begin
            v.rst  = ($urandom_range(0, 199) == 0);
            v.ic   = ($urandom_range(0, 3) != 0);
            v.is   = ($urandom_range(0, 3) != 0);
            v.ia   = $urandom;
            v.dc   = ($urandom_range(0, 3) != 0);
            v.ds   = ($urandom_range(0, 3) != 0);
            v.dwe  = $urandom_range(0, 1);
            v.dbe  = 4'($urandom);
            v.da   = $urandom;
            v.dd   = $urandom;
            v.md   = $urandom;
            v.mack = ($urandom_range(0, 3) == 0);
            step(v);
            model(v, e);
            chk_out("rnd", k, e);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
